// File: rtl/sr04_multi_ranger_if.sv
// Bus bundle for the multi-channel HC-SR04 ranging controller.
// The controller connects through the slave modport. The master modport is for
// whatever drives it, such as tick generators, sequencing logic or a testbench.
//   iEn/iStart      sweep control (continuous enable, single-sweep pulse)
//   iTick/imSec     shared 1us / 1ms strobes
//   iEcho           raw, asynchronous echo lines, one per sensor
//   oTrig           one-hot trigger while a channel is being fired
//   oDistance       packed per-channel distance in cm, channel k at [k*DIST_W +: DIST_W]
//   oValid/oValidCh one-cycle pulse and its channel when a distance is written
//   oError          sticky per-channel timeout flags
//   oBusy           controller is not idle
interface sr04_multi_ranger_if #(
    parameter int N_CH   = 4,
    parameter int DIST_W = 9,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                     iEn;
    logic                     iStart;
    logic                     iTick;
    logic                     imSec;
    logic [N_CH-1:0]          iEcho;
    logic [N_CH-1:0]          oTrig;
    logic [N_CH*DIST_W-1:0]   oDistance;
    logic                     oValid;
    logic [CH_W-1:0]          oValidCh;
    logic [N_CH-1:0]          oError;
    logic                     oBusy;

    modport slave (
        input  iEn, iStart, iTick, imSec, iEcho,
        output oTrig, oDistance, oValid, oValidCh, oError, oBusy
    );

    modport master (
        output iEn, iStart, iTick, imSec, iEcho,
        input  oTrig, oDistance, oValid, oValidCh, oError, oBusy
    );
endinterface

// File: rtl/sr04_multi_ranger.sv
// Multi-channel HC-SR04 ranging controller.
// A single FSM serves N_CH sensors in round-robin order. For each channel it
// fires the trigger, times the echo, converts the time to cm with a multi-cycle
// divider, and then waits out a hold-off gap before moving on.
// Ports:
//   iClk   system clock
//   iRst   asynchronous, active-high reset
//   bus    sr04_multi_ranger_if.slave (see the interface file for signal list)
// Build option:
//   SR04_AVG_EN  when defined, each stored distance is the average of the
//                previous stored value and the new result. The first result
//                after reset, or after a timeout on that channel, is loaded
//                directly.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for iStart or iEn
// TRIG      | trigger high on current channel for TRIG_US ticks
// WAIT_RISE | waiting for synchronised echo rising edge (timeout armed)
// MEASURE   | counting echo microseconds until falling edge (timeout armed)
// CALC      | repeated-subtraction divide of us by US_PER_CM
// GAP       | hold-off of GAP_MS ms, then next channel / wrap
module sr04_multi_ranger #(
    parameter int N_CH       = 4,
    parameter int DIST_W     = 9,
    parameter int MAX_CM     = 400,
    parameter int US_PER_CM  = 58,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_MS = 30,
    parameter int GAP_MS     = 60
) (
    input  logic               iClk,
    input  logic               iRst,
    sr04_multi_ranger_if.slave bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int US_MAX = MAX_CM * US_PER_CM;
    localparam int US_W   = $clog2(US_MAX + 1);
    localparam int TRIG_W = $clog2(TRIG_US + 1);
    localparam int MS_MAX = (TIMEOUT_MS > GAP_MS) ? TIMEOUT_MS : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_GAP
    } state_t;

    state_t                        state_q, state_d;
    logic [CH_W-1:0]               ch_q;
    logic [N_CH-1:0]               echo_s1_q, echo_s2_q, echo_s3_q;
    logic [TRIG_W-1:0]             trig_cnt_q;
    logic [MS_W-1:0]               ms_cnt_q;
    logic [US_W-1:0]               us_q;
    logic [DIST_W-1:0]             quot_q;
    logic [N_CH-1:0][DIST_W-1:0]   dist_q;
    logic [N_CH-1:0]               err_q;
    logic                          valid_q;
    logic [CH_W-1:0]               valid_ch_q;

    logic              rise, fall, trig_done, ms_done, calc_done, last_ch, timeout;
    logic [DIST_W-1:0] wr_dist;

    // Edges use stages 2 and 3, so an echo that is already high when WAIT_RISE
    // is entered shows no edge.
    assign rise      = echo_s2_q[ch_q] & ~echo_s3_q[ch_q];
    assign fall      = ~echo_s2_q[ch_q] & echo_s3_q[ch_q];
    assign trig_done = bus.iTick && (trig_cnt_q == TRIG_W'(1));
    assign ms_done   = bus.imSec && (ms_cnt_q == MS_W'(1));
    assign calc_done = (us_q < US_W'(US_PER_CM)) || (quot_q == DIST_W'(MAX_CM));
    assign last_ch   = (ch_q == CH_W'(N_CH - 1));
    assign timeout   = ((state_q == S_WAIT_RISE) || (state_q == S_MEASURE)) && ms_done;

`ifdef SR04_AVG_EN
    logic [N_CH-1:0] have_q;
    logic [DIST_W:0] avg_sum;

    assign avg_sum = {1'b0, dist_q[ch_q]} + {1'b0, quot_q};
    assign wr_dist = have_q[ch_q] ? DIST_W'(avg_sum >> 1) : quot_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            have_q <= '0;
        end else if (timeout) begin
            have_q[ch_q] <= 1'b0;
        end else if ((state_q == S_CALC) && calc_done) begin
            have_q[ch_q] <= 1'b1;
        end
    end
`else
    assign wr_dist = quot_q;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.iStart || bus.iEn) state_d = S_TRIG;
            S_TRIG:      if (trig_done) state_d = S_WAIT_RISE;
            S_WAIT_RISE: if (timeout) state_d = S_GAP;
                         else if (rise) state_d = S_MEASURE;
            S_MEASURE:   if (timeout) state_d = S_GAP;
                         else if (fall) state_d = S_CALC;
            S_CALC:      if (calc_done) state_d = S_GAP;
            S_GAP:       if (ms_done) state_d = (last_ch && !bus.iEn) ? S_IDLE : S_TRIG;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ch_q       <= '0;
            echo_s1_q  <= '0;
            echo_s2_q  <= '0;
            echo_s3_q  <= '0;
            trig_cnt_q <= '0;
            ms_cnt_q   <= '0;
            us_q       <= '0;
            quot_q     <= '0;
            dist_q     <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            valid_ch_q <= '0;
        end else begin
            echo_s1_q <= bus.iEcho;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
            valid_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_TRIG) begin
                        ch_q       <= '0;
                        trig_cnt_q <= TRIG_W'(TRIG_US);
                    end
                end
                S_TRIG: begin
                    if (bus.iTick) trig_cnt_q <= trig_cnt_q - TRIG_W'(1);
                    if (trig_done) begin
                        us_q     <= '0;
                        quot_q   <= '0;
                        ms_cnt_q <= MS_W'(TIMEOUT_MS);
                    end
                end
                S_WAIT_RISE, S_MEASURE: begin
                    if ((state_q == S_MEASURE) && bus.iTick && (us_q != US_W'(US_MAX)))
                        us_q <= us_q + US_W'(1);
                    if (timeout) begin
                        err_q[ch_q] <= 1'b1;
                        ms_cnt_q    <= MS_W'(GAP_MS);
                    end else if (bus.imSec) begin
                        ms_cnt_q <= ms_cnt_q - MS_W'(1);
                    end
                end
                S_CALC: begin
                    if (calc_done) begin
                        dist_q[ch_q] <= wr_dist;
                        err_q[ch_q]  <= 1'b0;
                        valid_q      <= 1'b1;
                        valid_ch_q   <= ch_q;
                        ms_cnt_q     <= MS_W'(GAP_MS);
                    end else begin
                        us_q   <= us_q - US_W'(US_PER_CM);
                        quot_q <= quot_q + DIST_W'(1);
                    end
                end
                S_GAP: begin
                    if (ms_done) begin
                        ch_q       <= last_ch ? '0 : ch_q + CH_W'(1);
                        trig_cnt_q <= TRIG_W'(TRIG_US);
                    end else if (bus.imSec) begin
                        ms_cnt_q <= ms_cnt_q - MS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // oTrig is decoded straight from the state register so that an async
    // reset drops the trigger without waiting for a clock edge.
    assign bus.oTrig     = (state_q == S_TRIG) ? (N_CH'(1) << ch_q) : '0;
    assign bus.oDistance = dist_q;
    assign bus.oValid    = valid_q;
    assign bus.oValidCh  = valid_ch_q;
    assign bus.oError    = err_q;
    assign bus.oBusy     = (state_q != S_IDLE);
endmodule
